// File: rtl/rtc_display_scanner.sv
// Scans the RTC register file into a staging bank and commits it to the display
// bank on a frame boundary; serves one registered BCD digit per cycle.
module rtc_display_scanner #(
  parameter int NREG           = 9,
  parameter int REFRESH_CYCLES = 1000000,
  parameter int READ_LAT       = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] addr_rd,
  input  logic [7:0] data_rd,
  input  logic       refresh_req,
  input  logic       frame_sync,
  input  logic [4:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       digit_valid,
  output logic       snapshot_valid,
  output logic       bcd_err,
  output logic       busy
);

  localparam int CW = $clog2(REFRESH_CYCLES + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] CAPT   = 3'd3;
  localparam logic [2:0] PEND   = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    wait_cnt;
  logic          pend_req;
  logic          fs_d;
  logic [7:0]    staging [NREG];
  logic [7:0]    display [NREG];
  logic          tc;
  logic          start;
  logic          fs_edge;
  logic          stage_err;
  logic          sel_in_range;
  logic [3:0]    sel_nibble;

  assign tc           = (ref_cnt == CW'(REFRESH_CYCLES - 1));
  assign start        = tc | refresh_req;
  assign fs_edge      = frame_sync & ~fs_d;
  assign busy         = (state != IDLE);
  assign sel_in_range = ({1'b0, digit_sel} < 6'(2 * NREG));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      fs_d    <= 1'b0;
    end else begin
      ref_cnt <= tc ? '0 : ref_cnt + 1'b1;
      fs_d    <= frame_sync;
    end
  end

  // Scan/commit sequencer; the snapshot only reaches the display bank in COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      addr_rd        <= '0;
      wait_cnt       <= '0;
      pend_req       <= 1'b0;
      snapshot_valid <= 1'b0;
      bcd_err        <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        staging[r] <= '0;
        display[r] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start || pend_req) begin
            addr_rd  <= '0;
            pend_req <= 1'b0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          wait_cnt <= '0;
          state    <= (READ_LAT == 0) ? CAPT : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'(READ_LAT - 1)) state <= CAPT;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        CAPT: begin
          for (int r = 0; r < NREG; r++)
            if (addr_rd == 4'(r)) staging[r] <= data_rd;
          if (addr_rd == 4'(NREG - 1)) begin
            state <= PEND;
          end else begin
            addr_rd <= addr_rd + 1'b1;
            state   <= ADDR;
          end
        end
        PEND: begin
          if (fs_edge) state <= COMMIT;
        end
        COMMIT: begin
          for (int r = 0; r < NREG; r++) display[r] <= staging[r];
          snapshot_valid <= 1'b1;
          bcd_err        <= stage_err;
          pend_req       <= 1'b0;
          if (pend_req) begin
            addr_rd <= '0;
            state   <= ADDR;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Requests arriving mid-scan merge into a single pending rescan.
      if (state != IDLE && start) pend_req <= 1'b1;
    end
  end

  always_comb begin
    stage_err = 1'b0;
    for (int r = 0; r < NREG; r++)
      if (staging[r][3:0] > 4'd9 || staging[r][7:4] > 4'd9) stage_err = 1'b1;
  end

  always_comb begin
    sel_nibble = '0;
    for (int r = 0; r < NREG; r++)
      if (digit_sel[4:1] == 4'(r))
        sel_nibble = digit_sel[0] ? display[r][7:4] : display[r][3:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_val   <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_val   <= sel_in_range ? sel_nibble : 4'd0;
      digit_valid <= snapshot_valid & sel_in_range;
    end
  end

endmodule

// File: tb/tb_rtc_display_scanner.sv
// Directed bench for rtc_display_scanner: table-driven digit reads plus
// hand-written sequences for scan timing, frame commit, merging and reset.
module tb_rtc_display_scanner;

  localparam int NREG           = 9;
  localparam int REFRESH_CYCLES = 4000;
  localparam int READ_LAT       = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr_rd;
  logic [7:0] data_rd;
  logic       refresh_req;
  logic       frame_sync;
  logic [4:0] digit_sel;
  logic [3:0] digit_val;
  logic       digit_valid;
  logic       snapshot_valid;
  logic       bcd_err;
  logic       busy;

  logic [7:0] mem [16];
  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [4:0] sel;
    logic [3:0] val;
    logic       valid;
  } vec_t;
  vec_t vecs [9];

  rtc_display_scanner #(
    .NREG(NREG), .REFRESH_CYCLES(REFRESH_CYCLES), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .addr_rd(addr_rd), .data_rd(data_rd),
    .refresh_req(refresh_req), .frame_sync(frame_sync), .digit_sel(digit_sel),
    .digit_val(digit_val), .digit_valid(digit_valid),
    .snapshot_valid(snapshot_valid), .bcd_err(bcd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model with one cycle of read latency.
  always @(posedge clk) data_rd <= mem[addr_rd];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [4:0] sel);
    digit_sel = sel;
    @(negedge clk);
  endtask

  task automatic pulseRefresh();
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic fullScan();
    pulseRefresh();
    repeat (40) @(negedge clk);
    pulseFrame();
    @(negedge clk);
    checkOutput("busy_after_commit", busy, 0);
  endtask

  initial begin
    vecs[0] = '{5'd0,  4'h9, 1'b1};
    vecs[1] = '{5'd1,  4'h5, 1'b1};
    vecs[2] = '{5'd5,  4'h1, 1'b1};
    vecs[3] = '{5'd2,  4'h4, 1'b1};
    vecs[4] = '{5'd3,  4'h3, 1'b1};
    vecs[5] = '{5'd4,  4'h2, 1'b1};
    vecs[6] = '{5'd17, 4'h8, 1'b1};
    vecs[7] = '{5'd18, 4'h0, 1'b0};
    vecs[8] = '{5'd31, 4'h0, 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h59; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h31;
    mem[4] = 8'h45; mem[5] = 8'h56; mem[6] = 8'h67; mem[7] = 8'h78; mem[8] = 8'h87;

    reset = 1'b0; refresh_req = 1'b0; frame_sync = 1'b0; digit_sel = 5'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", addr_rd, 0);
    checkOutput("rst_snap", snapshot_valid, 0);
    checkOutput("rst_dvalid", digit_valid, 0);
    reset = 1'b1;

    // Automatic scan starts at the refresh counter terminal count.
    repeat (REFRESH_CYCLES - 1) @(negedge clk);
    checkOutput("busy_before_tc", busy, 0);
    @(negedge clk);
    checkOutput("busy_at_tc", busy, 1);
    for (int r = 0; r < NREG; r++)
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("addr_reg%0d_c%0d", r, k), addr_rd, 8'(r));
        @(negedge clk);
      end
    checkOutput("pend_busy", busy, 1);
    checkOutput("pend_snap", snapshot_valid, 0);

    repeat (500) @(negedge clk);
    checkOutput("hold_snap", snapshot_valid, 0);
    checkOutput("hold_dval", digit_val, 0);
    checkOutput("hold_dvalid", digit_valid, 0);
    checkOutput("hold_busy", busy, 1);

    pulseFrame();
    checkOutput("commit_busy", busy, 1);
    @(negedge clk);
    checkOutput("commit_snap", snapshot_valid, 1);
    checkOutput("commit_bcd", bcd_err, 0);
    checkOutput("commit_busy_low", busy, 0);
    checkOutput("commit_old_val", digit_val, 0);
    checkOutput("commit_old_valid", digit_valid, 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sel);
      checkOutput($sformatf("vec%0d_val", i), digit_val, 8'(vecs[i].val));
      checkOutput($sformatf("vec%0d_valid", i), digit_valid, 8'(vecs[i].valid));
    end

    // Non-BCD content is flagged but passed through.
    mem[3] = 8'h3A;
    fullScan();
    checkOutput("bcd_err_set", bcd_err, 1);
    applyStimulus(5'd6);
    checkOutput("nonbcd_val", digit_val, 8'hA);
    checkOutput("nonbcd_valid", digit_valid, 1);
    applyStimulus(5'd7);
    checkOutput("reg3_hi", digit_val, 8'h3);
    mem[3] = 8'h31;
    fullScan();
    checkOutput("bcd_err_clr", bcd_err, 0);
    applyStimulus(5'd6);
    checkOutput("reg3_lo", digit_val, 8'h1);

    // Three requests during one scan merge into a single extra scan.
    pulseRefresh();
    repeat (4) @(negedge clk);
    pulseRefresh();
    repeat (4) @(negedge clk);
    pulseRefresh();
    repeat (4) @(negedge clk);
    pulseRefresh();
    repeat (30) @(negedge clk);
    pulseFrame();
    @(negedge clk);
    checkOutput("merge_rescan_busy", busy, 1);
    checkOutput("merge_rescan_addr", addr_rd, 0);
    repeat (40) @(negedge clk);
    pulseFrame();
    @(negedge clk);
    checkOutput("merge_idle", busy, 0);
    repeat (10) @(negedge clk);
    checkOutput("merge_stays_idle", busy, 0);

    // Asynchronous reset during the CAPT cycle of reg4.
    applyStimulus(5'd0);
    checkOutput("pre_rst_val", digit_val, 8'h9);
    pulseRefresh();
    repeat (14) @(negedge clk);
    checkOutput("pre_rst_addr", addr_rd, 8'h4);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_addr", addr_rd, 0);
    checkOutput("mid_rst_snap", snapshot_valid, 0);
    checkOutput("mid_rst_val", digit_val, 0);
    checkOutput("mid_rst_valid", digit_valid, 0);
    checkOutput("mid_rst_bcd", bcd_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_val", digit_val, 0);
    pulseFrame();
    @(negedge clk);
    checkOutput("idle_frame_no_commit", snapshot_valid, 0);
    pulseRefresh();
    repeat (10) @(negedge clk);
    pulseFrame();
    repeat (30) @(negedge clk);
    checkOutput("midscan_frame_no_commit", snapshot_valid, 0);
    checkOutput("fresh_pend_busy", busy, 1);
    pulseFrame();
    @(negedge clk);
    checkOutput("fresh_commit_snap", snapshot_valid, 1);
    applyStimulus(5'd0);
    checkOutput("fresh_val", digit_val, 8'h9);
    checkOutput("fresh_valid", digit_valid, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rtc_display_scanner.md
Name: rtc_display_scanner

Overview:
- Downstream consumer of the RTC controller's register memory read port (4-bit read address out, 8-bit read data back).
- Periodically scans the NREG time/date/timer registers into a staging bank, then commits the whole snapshot to a display bank only at a frame boundary, so the display never shows a torn value.
- Serves one BCD digit per request to the VGA text/digit renderer and flags non-BCD content.

Parameters:
- NREG, 9, number of consecutive registers scanned (addresses 0..NREG-1); legal range 1..16.
- REFRESH_CYCLES, 1000000, clk cycles between automatic scans.
- READ_LAT, 1, clk cycles from a stable address to valid read data; legal range 0..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr_rd  out  4  register address driven to the memory read port.
- data_rd  in  8  memory read data; two packed BCD digits.
- refresh_req  in  1  one-cycle pulse that forces a scan.
- frame_sync  in  1  vertical sync from the display timing generator; a rising edge marks the frame boundary.
- digit_sel  in  5  requested digit: index = 2*reg + nibble (0 = low nibble, 1 = high nibble).
- digit_val  out  4  registered digit value.
- digit_valid  out  1  digit_val is valid and in range.
- snapshot_valid  out  1  at least one snapshot has been committed.
- bcd_err  out  1  the last committed snapshot contained a nibble greater than 9.
- busy  out  1  a scan or a pending commit is in progress.

Behaviour:
- Reset (reset=0, asynchronous): all outputs, both banks, counters, the pending flag and the frame_sync edge register clear to 0. The FSM goes to IDLE.
- The refresh counter runs 0..REFRESH_CYCLES-1 and wraps. Its terminal count or refresh_req sets the start condition.
- FSM states: IDLE, ADDR, WAIT, CAPT, PEND, COMMIT.
- IDLE: if the start condition or pend_req is set, clear index i=0 and go to ADDR.
- ADDR (1 cycle): addr_rd=i.
- WAIT (READ_LAT cycles, skipped when READ_LAT=0): addr_rd is held.
- CAPT (1 cycle): staging[i] <= data_rd. If i=NREG-1, go to PEND; otherwise i++ and return to ADDR.
- Scan cost per register: READ_LAT+2 cycles. addr_rd holds its last value outside a scan.
- PEND: wait for a frame_sync rising edge. Edge detection uses a 1-flop delayed copy of frame_sync. An edge in the same cycle the FSM enters PEND does not count.
- COMMIT (1 cycle):
  - display bank <= staging bank;
  - snapshot_valid <= 1, sticky;
  - bcd_err <= OR over all staging nibbles of (nibble > 9);
  - next state: ADDR if pend_req is set (clear it), else IDLE.
- pend_req: set by refresh_req or a counter terminal count while the FSM is in ADDR..COMMIT. It holds at most one pending scan; extra requests merge.
- busy=1 in every state except IDLE.
- Digit read is one-cycle registered: on each clk, digit_val <= nibble(display[digit_sel>>1], digit_sel[0]).
- digit_valid <= snapshot_valid AND (digit_sel < 2*NREG).
  - Out-of-range digit_sel: digit_val=0, digit_valid=0.
  - A non-BCD nibble is passed through unchanged; only bcd_err reports it.
- A commit and a digit read in the same cycle: the read returns the old display bank value. The new value is visible one cycle later.
- Reset mid-scan or in PEND: no partial commit. The display bank is cleared and snapshot_valid=0.

Test Plan:
- Reset, then release; memory holds reg0=0x59, reg1=0x34, reg2=0x12 -> all outputs are 0 until the first commit. busy rises at the counter terminal count (cycle REFRESH_CYCLES). addr_rd steps 0,1,..,8 with 3 cycles per register at READ_LAT=1.
- After the scan, hold frame_sync=0 for 500 cycles, then pulse it -> the display bank is unchanged until the edge. On the commit cycle snapshot_valid=1. digit_sel=0 gives 9, digit_sel=1 gives 5, digit_sel=5 gives 1, each one cycle after the request.
- Set reg3=0x3A and pulse refresh_req -> after the commit, bcd_err=1 and digit_sel=6 returns 0xA with digit_valid=1. Restore reg3=0x31 and rescan -> bcd_err=0.
- Pulse refresh_req 3 times during a scan -> exactly one extra scan starts on the cycle after COMMIT, then the FSM returns to IDLE.
- digit_sel=18 with NREG=9 -> digit_val=0, digit_valid=0.
- Assert reset at the CAPT state of reg4 -> all outputs are 0 immediately (asynchronously). After release, the first commit needs a full fresh scan.
